// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Purpose  : Shared pattern ROM contents, animation mode encodings and helpers.
// Revision : 1.0
// ============================================================================
package matrix_pkg;

  localparam int PKG_FRAMES = 4;
  localparam int PKG_ROWS   = 8;
  localparam int PKG_COLS   = 5;

  typedef enum logic [1:0] {
    MODE_STATIC   = 2'd0,
    MODE_LOOP     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_ONESHOT  = 2'd3
  } mode_e;

  typedef logic [PKG_COLS-1:0] row_bits_t;

  // Bit 4 is the leftmost column; row 0 is the top row.
  localparam row_bits_t PATTERNS [PKG_FRAMES][PKG_ROWS] = '{
    '{5'b11111, 5'b10000, 5'b11111, 5'b00000, 5'b11111, 5'b10101, 5'b10101, 5'b00000},
    '{5'b00100, 5'b01110, 5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000},
    '{5'b10001, 5'b01010, 5'b00100, 5'b01010, 5'b10001, 5'b00000, 5'b11111, 5'b00000},
    '{5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b01110, 5'b00000, 5'b01010, 5'b00000}
  };

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_frame_rom.sv
`default_nettype none
// ============================================================================
// Module   : matrix_frame_rom
// Purpose  : Combinational lookup of one row's column pattern; unknown cells read 0.
// Revision : 1.0
// ============================================================================
module matrix_frame_rom
  import matrix_pkg::*;
#(
  parameter int  COLS   = 5,
  parameter int  ROWS   = 8,
  parameter int  FRAMES = 4,
  localparam int RW     = clog2_min1(ROWS),
  localparam int FW     = clog2_min1(FRAMES)
) (
  input  logic [FW-1:0]   frame_i,
  input  logic [RW-1:0]   row_i,
  output logic [COLS-1:0] colunas_o
);

  localparam int C_WIDE = (COLS > PKG_COLS) ? COLS : PKG_COLS;

  logic [C_WIDE-1:0] w_pattern;

  always_comb begin
    w_pattern = '0;
    for (int f = 0; f < PKG_FRAMES; f++) begin
      for (int r = 0; r < PKG_ROWS; r++) begin
        if (int'(frame_i) == f && int'(row_i) == r) begin
          w_pattern[PKG_COLS-1:0] = PATTERNS[f][r];
        end
      end
    end
  end

  assign colunas_o = w_pattern[COLS-1:0];

endmodule
`default_nettype wire

// File: rtl/matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scanner
// Purpose  : Row-multiplexed LED-matrix driver with automatic frame animation.
// Revision : 1.0
// ============================================================================
module matrix_scanner
  import matrix_pkg::*;
#(
  parameter int  COLS     = 5,
  parameter int  ROWS     = 8,
  parameter int  FRAMES   = 4,
  parameter int  SCAN_DIV = 1000,
  parameter int  HOLD     = 50,
  localparam int RW       = clog2_min1(ROWS),
  localparam int FW       = clog2_min1(FRAMES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic [FW-1:0]   frame_sel,
  input  logic            restart,
  output logic [ROWS-1:0] linhas,
  output logic [COLS-1:0] colunas,
  output logic [RW-1:0]   row_idx,
  output logic [FW-1:0]   frame_idx,
  output logic            frame_wrap,
  output logic            done
);

  localparam int            DW           = clog2_min1(SCAN_DIV);
  localparam int            SW           = clog2_min1(HOLD);
  localparam logic [DW-1:0] C_DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] C_ROW_LAST   = RW'(ROWS - 1);
  localparam logic [SW-1:0] C_SCAN_LAST  = SW'(HOLD - 1);
  localparam logic [FW-1:0] C_FRAME_LAST = FW'(FRAMES - 1);
  localparam logic          C_DIR_UP     = 1'b0;
  localparam logic          C_DIR_DOWN   = 1'b1;

  // Scan state
  logic [DW-1:0] div_q,   div_d;
  logic [RW-1:0] row_q,   row_d;
  logic [SW-1:0] scans_q, scans_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          dir_q,   dir_d;
  logic          done_q,  done_d;

  // Output registers
  logic [ROWS-1:0] linhas_q,    linhas_d;
  logic [COLS-1:0] colunas_q,   colunas_d;
  logic [RW-1:0]   row_idx_q;
  logic [FW-1:0]   frame_idx_q;
  logic            frame_wrap_q;
  logic            done_out_q;

  logic [FW-1:0]   w_sel;
  logic [FW-1:0]   w_step_frame;
  logic            w_step_dir;
  logic            w_step_done;
  logic [COLS-1:0] w_rom_cols;

  // Out-of-range selections are only possible when FRAMES is not a power of two.
  generate
    if ((1 << FW) != FRAMES) begin : g_sel_clamp
      assign w_sel = (frame_sel > C_FRAME_LAST) ? C_FRAME_LAST : frame_sel;
    end else begin : g_sel_direct
      assign w_sel = frame_sel;
    end
  endgenerate

  always_comb begin
    w_step_frame = frame_q;
    w_step_dir   = dir_q;
    w_step_done  = done_q;
    unique case (mode_e'(mode))
      MODE_STATIC: w_step_frame = w_sel;
      MODE_LOOP:   w_step_frame = (frame_q == C_FRAME_LAST) ? '0 : frame_q + 1'b1;
      MODE_PINGPONG: begin
        if (FRAMES == 1) begin
          w_step_frame = '0;
        end else if (dir_q == C_DIR_UP) begin
          if (frame_q >= C_FRAME_LAST) begin
            w_step_frame = frame_q - 1'b1;
            w_step_dir   = C_DIR_DOWN;
          end else begin
            w_step_frame = frame_q + 1'b1;
          end
        end else begin
          if (frame_q == '0) begin
            w_step_frame = frame_q + 1'b1;
            w_step_dir   = C_DIR_UP;
          end else begin
            w_step_frame = frame_q - 1'b1;
          end
        end
      end
      MODE_ONESHOT: begin
        if (frame_q < C_FRAME_LAST) begin
          w_step_frame = frame_q + 1'b1;
        end
        if (w_step_frame == C_FRAME_LAST) begin
          w_step_done = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    div_d   = div_q;
    row_d   = row_q;
    scans_d = scans_q;
    frame_d = frame_q;
    dir_d   = dir_q;
    done_d  = done_q;
    if (restart) begin
      div_d   = '0;
      row_d   = '0;
      scans_d = '0;
      frame_d = w_sel;
      dir_d   = C_DIR_UP;
      done_d  = 1'b0;
    end else if (enable) begin
      if (div_q == C_DIV_LAST) begin
        div_d = '0;
        if (row_q == C_ROW_LAST) begin
          row_d = '0;
          if (scans_q == C_SCAN_LAST) begin
            scans_d = '0;
            frame_d = w_step_frame;
            dir_d   = w_step_dir;
            done_d  = w_step_done;
          end else begin
            scans_d = scans_q + 1'b1;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  matrix_frame_rom #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .FRAMES (FRAMES)
  ) u_rom (
    .frame_i   (frame_q),
    .row_i     (row_q),
    .colunas_o (w_rom_cols)
  );

  // The output registers present the state being displayed this clock; div = 0 is blanked.
  always_comb begin
    linhas_d  = '0;
    colunas_d = '0;
    if (enable) begin
      linhas_d  = ROWS'(1) << row_q;
      colunas_d = (div_q != '0) ? w_rom_cols : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      row_q        <= '0;
      scans_q      <= '0;
      frame_q      <= '0;
      dir_q        <= C_DIR_UP;
      done_q       <= 1'b0;
      linhas_q     <= '0;
      colunas_q    <= '0;
      row_idx_q    <= '0;
      frame_idx_q  <= '0;
      frame_wrap_q <= 1'b0;
      done_out_q   <= 1'b0;
    end else begin
      div_q        <= div_d;
      row_q        <= row_d;
      scans_q      <= scans_d;
      frame_q      <= frame_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
      linhas_q     <= linhas_d;
      colunas_q    <= colunas_d;
      row_idx_q    <= row_q;
      frame_idx_q  <= frame_q;
      frame_wrap_q <= (frame_q != frame_idx_q);
      done_out_q   <= done_q;
    end
  end

  assign linhas     = linhas_q;
  assign colunas    = colunas_q;
  assign row_idx    = row_idx_q;
  assign frame_idx  = frame_idx_q;
  assign frame_wrap = frame_wrap_q;
  assign done       = done_out_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scanner
// Purpose  : Directed self-checking bench for matrix_scanner (SCAN_DIV=4, HOLD=2).
// Revision : 1.0
// ============================================================================
module tb_matrix_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic [1:0] frame_sel;
  logic       restart;
  logic [7:0] linhas;
  logic [4:0] colunas;
  logic [2:0] row_idx;
  logic [1:0] frame_idx;
  logic       frame_wrap;
  logic       done;

  int checks = 0;
  int passes = 0;

  localparam logic [4:0] FRAME0 [8] = '{5'b11111, 5'b10000, 5'b11111, 5'b00000,
                                        5'b11111, 5'b10101, 5'b10101, 5'b00000};
  localparam int PP_SEQ [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

  typedef struct {
    logic [7:0] linhas;
    logic [4:0] colunas;
    logic [2:0] row;
  } vec_t;

  vec_t vec [32];

  matrix_scanner #(
    .COLS     (5),
    .ROWS     (8),
    .FRAMES   (4),
    .SCAN_DIV (4),
    .HOLD     (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .frame_sel  (frame_sel),
    .restart    (restart),
    .linhas     (linhas),
    .colunas    (colunas),
    .row_idx    (row_idx),
    .frame_idx  (frame_idx),
    .frame_wrap (frame_wrap),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic do_reset(input logic [1:0] m);
    reset     = 1'b1;
    enable    = 1'b0;
    restart   = 1'b0;
    tick();
    reset     = 1'b0;
    enable    = 1'b1;
    mode      = m;
    frame_sel = 2'd0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'd0; frame_sel = 2'd0; restart = 1'b0;

    for (int c = 0; c < 32; c++) begin
      vec[c].linhas  = 8'(1) << (c / 4);
      vec[c].colunas = (c % 4 == 0) ? 5'b00000 : FRAME0[c / 4];
      vec[c].row     = 3'(c / 4);
    end

    // Reset state
    tick(); tick();
    check("rst_linhas",     32'(linhas),     32'h0);
    check("rst_colunas",    32'(colunas),    32'h0);
    check("rst_row_idx",    32'(row_idx),    32'h0);
    check("rst_frame_idx",  32'(frame_idx),  32'h0);
    check("rst_frame_wrap", 32'(frame_wrap), 32'h0);
    check("rst_done",       32'(done),       32'h0);

    // Static scan of frame 0, table-driven
    do_reset(2'd0);
    for (int c = 0; c < 32; c++) begin
      tick();
      check($sformatf("static_linhas[%0d]", c),  32'(linhas),  32'(vec[c].linhas));
      check($sformatf("static_colunas[%0d]", c), 32'(colunas), 32'(vec[c].colunas));
      check($sformatf("static_row[%0d]", c),     32'(row_idx), 32'(vec[c].row));
    end

    // Loop mode: 4 frame periods
    do_reset(2'd1);
    for (int e = 0; e <= 256; e++) begin
      tick();
      check($sformatf("loop_frame[%0d]", e), 32'(frame_idx), 32'((e / 64) % 4));
      check($sformatf("loop_wrap[%0d]", e),  32'(frame_wrap), 32'((e > 0 && e % 64 == 0) ? 1 : 0));
    end

    // Ping-pong: 7 frame periods
    do_reset(2'd2);
    for (int e = 0; e <= 448; e++) begin
      tick();
      check($sformatf("pp_frame[%0d]", e), 32'(frame_idx), 32'(PP_SEQ[e / 64]));
    end

    // One-shot: reaches frame 3, sets done, stops wrapping
    do_reset(2'd3);
    for (int e = 0; e <= 300; e++) begin
      tick();
      check($sformatf("os_frame[%0d]", e), 32'(frame_idx), 32'((e / 64 > 3) ? 3 : e / 64));
      check($sformatf("os_done[%0d]", e),  32'(done),      32'((e >= 192) ? 1 : 0));
      check($sformatf("os_wrap[%0d]", e),  32'(frame_wrap),
            32'((e == 64 || e == 128 || e == 192) ? 1 : 0));
    end
    frame_sel = 2'd1;
    restart   = 1'b1;
    tick();
    restart   = 1'b0;
    tick();
    check("restart_row_idx",   32'(row_idx),    32'h0);
    check("restart_frame_idx", 32'(frame_idx),  32'h1);
    check("restart_done",      32'(done),       32'h0);
    check("restart_wrap",      32'(frame_wrap), 32'h1);
    check("restart_linhas",    32'(linhas),     32'h1);
    check("restart_colunas",   32'(colunas),    32'h0);

    // Enable dropped mid row 5, then resumed
    do_reset(2'd0);
    for (int e = 0; e <= 21; e++) tick();
    check("pre_drop_linhas", 32'(linhas), 32'h20);
    enable = 1'b0;
    tick();
    check("off_linhas",  32'(linhas),  32'h0);
    check("off_colunas", 32'(colunas), 32'h0);
    tick();
    check("off_linhas2", 32'(linhas),  32'h0);
    check("off_row_idx", 32'(row_idx), 32'h5);
    enable = 1'b1;
    tick();
    check("resume_linhas",   32'(linhas),  32'h20);
    check("resume_colunas",  32'(colunas), 32'(5'b10101));
    tick();
    check("resume_colunas2", 32'(colunas), 32'(5'b10101));
    tick();
    check("resume_next_row", 32'(linhas),  32'h40);
    check("resume_blank",    32'(colunas), 32'h0);

    // Reset at row 6 of frame 2 in loop mode
    do_reset(2'd1);
    for (int e = 0; e <= 153; e++) tick();
    check("f2r6_frame",   32'(frame_idx), 32'h2);
    check("f2r6_linhas",  32'(linhas),    32'h40);
    check("f2r6_colunas", 32'(colunas),   32'(5'b11111));
    reset = 1'b1;
    tick();
    check("midrst_linhas",    32'(linhas),     32'h0);
    check("midrst_colunas",   32'(colunas),    32'h0);
    check("midrst_row_idx",   32'(row_idx),    32'h0);
    check("midrst_frame_idx", 32'(frame_idx),  32'h0);
    check("midrst_wrap",      32'(frame_wrap), 32'h0);
    check("midrst_done",      32'(done),       32'h0);
    reset = 1'b0;
    tick();
    check("post_rst_linhas",  32'(linhas),    32'h1);
    check("post_rst_colunas", 32'(colunas),   32'h0);
    check("post_rst_frame",   32'(frame_idx), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
